imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate extender: widens an IN_W-bit immediate to OUT_W bits under a per-transaction mode.
//  Modes are sign, zero, upper-place and branch-offset.
//  Valid/ready on both sides; 2-entry skid buffer gives full throughput with registered in_ready.
//  Sits between instruction decode and the ALU operand mux.
// PARAMETERS
//  IN_W   4   immediate input width; must satisfy 1 <= IN_W < OUT_W (elaboration $error otherwise)
//  OUT_W  16  extended output width
//  CNT_W  16  width of transfer counter (only with IMMEXT_STATS_EN)
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-low reset
//  in_valid   in   1      input transaction valid
//  in_ready   out  1      block can accept input this cycle
//  in_imm     in   IN_W   raw immediate
//  in_mode    in   2      imm_ext_pkg::ext_mode_e
//  out_valid  out  1      extended result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  OUT_W  extended result
//  xfer_count out  CNT_W  output transfers completed (IMMEXT_STATS_EN only)
// BEHAVIOUR
//  Modes:
//   - 00 SIGN: replicate in_imm[IN_W-1].
//   - 01 ZERO: zero-fill.
//   - 10 UPPER: {in_imm, (OUT_W-IN_W)'0}.
//   - 11 BRANCH: SIGN result << 1; MSB of the SIGN result is discarded, LSB = 0.
//  Extension is computed combinationally at the input; only extended values are stored.
//  Transfer rule: input xfer = in_valid & in_ready; output xfer = out_valid & out_ready.
//  Latency: an accepted input appears on out_data the next cycle when the block is empty.
//  Throughput: 1/cycle while out_ready=1.
//  State machine (occupancy):
//   - EMPTY -> ONE on input xfer.
//   - ONE   -> EMPTY on output xfer without input xfer; stays ONE on output and input xfer together.
//   - ONE   -> TWO on input xfer without output xfer.
//   - TWO   -> ONE on output xfer; in_ready=0 in TWO, so no input xfer is possible.
//  in_ready is a register: 1 in EMPTY and ONE, 0 in TWO. No combinational path from out_ready to in_ready.
//  Ordering is strict FIFO. The skid entry moves to the output register on the output xfer that leaves TWO.
//  out_data and out_valid are driven only from the main register. out_data holds stable while out_valid & ~out_ready.
//  Simultaneous input and output xfer in ONE: new value replaces the output register. Nothing is lost or duplicated.
//  in_valid while in_ready=0: ignored; the source must hold in_imm/in_mode stable.
//  Reset (reset==0 at a clk edge), including mid-operation: both entries are discarded.
//   - State goes to EMPTY; out_valid=0, out_data='0, in_ready=0 while reset is held.
//   - in_ready=1 on the first cycle after release.
//  out_data is '0 whenever out_valid=0 after reset; otherwise it holds the last value.
// CONFIGURATION
//  IMMEXT_STATS_EN defined:
//   - xfer_count port exists; it increments on every output xfer and wraps 2^CNT_W-1 -> 0.
//   - It resets to 0 with reset.
//  IMMEXT_STATS_EN undefined: no counter and no xfer_count port. All other behaviour is identical.
// STRUCTURE
//  imm_ext_pkg:
//   - typedef enum logic [1:0] ext_mode_e {EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH}
//   - typedef enum logic [1:0] occ_e {OCC_EMPTY, OCC_ONE, OCC_TWO}
//  Sub-module imm_ext_skid #(W): generic 2-entry valid/ready skid buffer holding OUT_W data.
//  The mode decode and counter live in imm_extend_pipe.
// TESTING
//  Bench is self-checking and driven from imm_extend_pipe_tb.tv via $readmemh. Vector = {mode, imm, out_ready, expected}.
//  Checks run on the negedge; the run ends at the first all-x vector and prints the error count. Directed cases use IN_W=4, OUT_W=16:
//  1 Modes, in_imm=4'h8: SIGN->16'hFFF8, ZERO->16'h0008, UPPER->16'h8000, BRANCH->16'hFFF0. in_imm=4'h7 BRANCH -> 16'h000E.
//  2 Streaming: out_ready=1 and in_imm 0..F sent back to back -> 16 results in order on consecutive cycles, in_ready stays 1.
//  3 Backpressure: out_ready=0 while sending 3'h1,2,3 (SIGN).
//    - in_ready drops after 2 accepts; out_data holds 16'h0001.
//    - Releasing out_ready yields 0001, 0002, 0003 with no loss.
//  4 Simultaneous: in ONE with out_ready=1 and a new input -> occupancy stays ONE, the new value appears next cycle.
//  5 Reset mid-operation: reset=0 in TWO -> next edge out_valid=0, out_data=0, in_ready=0.
//    - After release, in_ready=1 and no stale data is emitted.
//  6 IMMEXT_STATS_EN, CNT_W=4: 17 output xfers -> xfer_count=1 (wrap); reset returns it to 0.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// ----------------------------------------------------------------------------
// imm_ext_pkg
//   Shared types for the immediate extender pipeline.
//   ext_mode_e : per-transaction extension mode carried on in_mode.
//   occ_e      : occupancy of the 2-entry skid buffer.
// ----------------------------------------------------------------------------
package imm_ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_TWO   = 2'b10
    } occ_e;

endpackage

// File: rtl/imm_ext_skid.sv
// ----------------------------------------------------------------------------
// imm_ext_skid
//   Generic 2-entry valid/ready skid buffer with a registered in_ready.
//   Output is driven only from the main register; the skid register catches
//   the one extra beat that can arrive while in_ready is still high.
//
// Parameters
//   W          data width
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   in_valid   upstream data valid
//   in_ready   buffer can accept (registered; 0 only when both entries full)
//   in_data    upstream data
//   out_valid  main register holds data
//   out_ready  downstream accepts
//   out_data   main register contents ('0 after reset until first load)
// ----------------------------------------------------------------------------
module imm_ext_skid
    import imm_ext_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         state;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign out_data = main_data;

    // in_ready is loaded with "next state is not TWO" so it never depends
    // combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= OCC_EMPTY;
            main_data <= '0;
            skid_data <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    in_ready <= 1'b1;
                    if (in_xfer) begin
                        main_data <= in_data;
                        out_valid <= 1'b1;
                        state     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && out_xfer) begin
                        // Old beat leaves while the new one takes its place.
                        main_data <= in_data;
                        in_ready  <= 1'b1;
                    end else if (in_xfer) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= OCC_TWO;
                    end else if (out_xfer) begin
                        // main_data keeps its last value; only valid drops.
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= OCC_EMPTY;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (out_xfer) begin
                        main_data <= skid_data;
                        in_ready  <= 1'b1;
                        state     <= OCC_ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= OCC_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// ----------------------------------------------------------------------------
// imm_extend_pipe
//   Pipelined immediate extender between decode and the ALU operand mux.
//   Widens an IN_W-bit immediate to OUT_W bits by mode (sign, zero, upper,
//   branch offset). Extension is combinational at the input; a 2-entry skid
//   buffer stores the extended values and gives full throughput with a
//   registered in_ready.
//
// Configuration macro
//   IMMEXT_STATS_EN : adds xfer_count, a wrapping count of output transfers.
//
// Parameters
//   IN_W       immediate width, 1 <= IN_W < OUT_W
//   OUT_W      extended width
//   CNT_W      transfer counter width (used only with IMMEXT_STATS_EN)
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   in_valid   input transaction valid
//   in_ready   block can accept input this cycle
//   in_imm     raw immediate
//   in_mode    extension mode (ext_mode_e)
//   out_valid  extended result valid
//   out_ready  downstream accepts result
//   out_data   extended result
//   xfer_count output transfers completed (IMMEXT_STATS_EN only)
// ----------------------------------------------------------------------------
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  ext_mode_e        in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMMEXT_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_count
`endif
);

    if ((IN_W < 1) || (IN_W >= OUT_W)) begin : g_bad_width
        $error("imm_extend_pipe: IN_W=%0d must satisfy 1 <= IN_W < OUT_W=%0d", IN_W, OUT_W);
    end

    if (CNT_W < 1) begin : g_bad_cnt
        $error("imm_extend_pipe: CNT_W must be at least 1");
    end

    localparam int unsigned PadW = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] branch_ext;
    logic [OUT_W-1:0] ext_data;

    assign sign_ext   = {{PadW{in_imm[IN_W-1]}}, in_imm};
    assign zero_ext   = {{PadW{1'b0}}, in_imm};
    assign upper_ext  = {in_imm, {PadW{1'b0}}};
    // Branch offsets are halfword-scaled: drop the sign MSB, append a zero.
    assign branch_ext = {sign_ext[OUT_W-2:0], 1'b0};

    always_comb begin
        ext_data = sign_ext;
        case (in_mode)
            EXT_SIGN:   ext_data = sign_ext;
            EXT_ZERO:   ext_data = zero_ext;
            EXT_UPPER:  ext_data = upper_ext;
            EXT_BRANCH: ext_data = branch_ext;
            default:    ext_data = sign_ext;
        endcase
    end

    imm_ext_skid #(
        .W (OUT_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (ext_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

`ifdef IMMEXT_STATS_EN
    // Wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!reset) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end
`endif

endmodule
